// File: rtl/ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the control-word pipeline: the NZCV flag type, the
// flag count and the bit position of each flag inside a flags_t.
// -----------------------------------------------------------------------------
package ctrl_pipe_pkg;

    localparam int NFLAGS = 4;

    typedef logic [NFLAGS-1:0] flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam flags_t FLAGS_CLEAR = 4'b0000;

endpackage : ctrl_pipe_pkg

// File: rtl/ctrl_stage.sv
// -----------------------------------------------------------------------------
// ctrl_stage
// One pipeline slot: a WIDTH-bit control word plus its valid bit.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears word and valid)
//   en       : advance enable; when low the slot holds its contents
//   clr      : synchronous clear, wins over en (used for flush)
//   in_valid : valid bit arriving from the previous slot / pipe input
//   in_cntrl : control word arriving from the previous slot / pipe input
//   valid    : registered valid bit
//   cntrl    : registered control word (all zero whenever valid is zero)
// -----------------------------------------------------------------------------
module ctrl_stage #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_cntrl,
    output logic             valid,
    output logic [WIDTH-1:0] cntrl
);

    // Slot register: reset/clear to zero, capture on enable, otherwise hold.
    // A bubble entering the slot is stored as an all-zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            cntrl <= {WIDTH{1'b0}};
        end else if (clr) begin
            valid <= 1'b0;
            cntrl <= {WIDTH{1'b0}};
        end else if (en) begin
            valid <= in_valid;
            cntrl <= in_valid ? in_cntrl : {WIDTH{1'b0}};
        end else begin
            valid <= valid;
            cntrl <= cntrl;
        end
    end

endmodule : ctrl_stage

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Decoded control words travel down DEPTH slots alongside the datapath. The
// word in stage 0 may request an NZCV flag update from the execute stage.
//
// Parameters
//   WIDTH       : control word width
//   DEPTH       : number of stages (1..8)
//   FLAG_EN_BIT : bit of the stage-0 word that enables the flag write
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   in_valid    : new control word presented
//   in_cntrl    : control word entering stage 0
//   stall       : freeze all stages and flags
//   flush       : clear all stages (wins over stall)
//   alu_flags   : NZCV from execute
//   stage_cntrl : per-stage word, stage k at [k*WIDTH +: WIDTH]
//   stage_valid : per-stage valid
//   occupancy   : number of valid stages
//   flags       : registered NZCV
//   flags_fwd   : flags seen by a same-cycle consumer
//
// Build option: define CTRL_PIPE_FWD_EN to bypass alu_flags onto flags_fwd
// during a cycle that writes the flag register.
// -----------------------------------------------------------------------------
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH       = 20,
    parameter int DEPTH       = 3,
    parameter int FLAG_EN_BIT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_cntrl,
    input  logic                       stall,
    input  logic                       flush,
    input  flags_t                     alu_flags,
    output logic [DEPTH*WIDTH-1:0]     stage_cntrl,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output flags_t                     flags,
    output flags_t                     flags_fwd
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic advance_s;
    logic flag_wr_s;
    logic [OCC_W-1:0] occ_s;

    assign advance_s = ~stall;

    // Slot chain: stage 0 fed from the pipe input, stage k from stage k-1.
    // The last stage simply drops out, so the pipe never backpressures.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             vin_s;
        logic [WIDTH-1:0] cin_s;

        if (k == 0) begin : g_head
            assign vin_s = in_valid;
            assign cin_s = in_cntrl;
        end else begin : g_tail
            assign vin_s = stage_valid[k-1];
            assign cin_s = stage_cntrl[(k-1)*WIDTH +: WIDTH];
        end

        ctrl_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (reset),
            .en       (advance_s),
            .clr      (flush),
            .in_valid (vin_s),
            .in_cntrl (cin_s),
            .valid    (stage_valid[k]),
            .cntrl    (stage_cntrl[k*WIDTH +: WIDTH])
        );
    end

    // A held or killed stage-0 word must not commit its flag update.
    assign flag_wr_s = stage_valid[0] & stage_cntrl[FLAG_EN_BIT] & ~stall & ~flush;

    // NZCV flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= FLAGS_CLEAR;
        end else if (flag_wr_s) begin
            flags <= alu_flags;
        end else begin
            flags <= flags;
        end
    end

    // Population count of the valid bits.
    always_comb begin
        occ_s = {OCC_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            occ_s = occ_s + OCC_W'(stage_valid[i]);
        end
    end

    assign occupancy = occ_s;

`ifdef CTRL_PIPE_FWD_EN
    // Bypass: a consumer in the writing cycle sees the value being written.
    always_comb begin
        flags_fwd = flags;
        if (flag_wr_s) begin
            flags_fwd = alu_flags;
        end else begin
            flags_fwd = flags;
        end
    end
`else
    assign flags_fwd = flags;
`endif

endmodule : ctrl_pipe

// File: tb/tb_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipe
// Directed bench for ctrl_pipe at WIDTH=20, DEPTH=3, FLAG_EN_BIT=15.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_ctrl_pipe;

    localparam int WIDTH = 20;
    localparam int DEPTH = 3;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_cntrl;
    logic                   stall;
    logic                   flush;
    logic [3:0]             alu_flags;
    logic [DEPTH*WIDTH-1:0] stage_cntrl;
    logic [DEPTH-1:0]       stage_valid;
    logic [1:0]             occupancy;
    logic [3:0]             flags;
    logic [3:0]             flags_fwd;

    int n_vec;
    int n_err;

    ctrl_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .FLAG_EN_BIT(15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_cntrl    (in_cntrl),
        .stall       (stall),
        .flush       (flush),
        .alu_flags   (alu_flags),
        .stage_cntrl (stage_cntrl),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .flags       (flags),
        .flags_fwd   (flags_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_cntrl = 20'h0; stall = 1'b0;
        flush = 1'b0; alu_flags = 4'b0000;
        #2;
        n_vec++;
        if (stage_valid !== 3'b000 || stage_cntrl !== 60'h0 || occupancy !== 2'd0
            || flags !== 4'b0000 || flags_fwd !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: valid=%b cntrl=%h occ=%0d flags=%b fwd=%b, need all zero",
                     stage_valid, stage_cntrl, occupancy, flags, flags_fwd);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic [59:0] exp_c [4];
        logic [2:0]  exp_v [4];
        logic [1:0]  exp_o [4];
        exp_c[0] = {20'h0, 20'h0, 20'h08001}; exp_v[0] = 3'b001; exp_o[0] = 2'd1;
        exp_c[1] = {20'h0, 20'h08001, 20'h0}; exp_v[1] = 3'b010; exp_o[1] = 2'd1;
        exp_c[2] = {20'h08001, 20'h0, 20'h0}; exp_v[2] = 3'b100; exp_o[2] = 2'd1;
        exp_c[3] = 60'h0;                     exp_v[3] = 3'b000; exp_o[3] = 2'd0;
        in_valid = 1'b1; in_cntrl = 20'h08001;
        for (int e = 0; e < 4; e++) begin
            step();
            // Junk on in_cntrl with in_valid low must enter as a zero bubble.
            in_valid = 1'b0; in_cntrl = 20'hFFFFF;
            n_vec++;
            if (stage_valid !== exp_v[e] || stage_cntrl !== exp_c[e] || occupancy !== exp_o[e]) begin
                n_err++;
                $display("FAIL latency_edge%0d: valid=%b cntrl=%h occ=%0d, need valid=%b cntrl=%h occ=%0d",
                         e + 1, stage_valid, stage_cntrl, occupancy, exp_v[e], exp_c[e], exp_o[e]);
            end
        end
        in_cntrl = 20'h0;
    endtask

    task automatic test_flags();
        logic [3:0] exp_fwd;
        in_valid = 1'b1; in_cntrl = 20'h08000;
        step();
        in_valid = 1'b0; in_cntrl = 20'h0; alu_flags = 4'b0110;
        #1;
`ifdef CTRL_PIPE_FWD_EN
        exp_fwd = 4'b0110;
`else
        exp_fwd = 4'b0000;
`endif
        n_vec++;
        if (flags_fwd !== exp_fwd || flags !== 4'b0000) begin
            n_err++;
            $display("FAIL flag_fwd_same_cycle: fwd=%b flags=%b, need fwd=%b flags=0000",
                     flags_fwd, flags, exp_fwd);
        end
        step();
        n_vec++;
        if (flags !== 4'b0110 || flags_fwd !== 4'b0110) begin
            n_err++;
            $display("FAIL flag_write: flags=%b fwd=%b, need 0110", flags, flags_fwd);
        end
        // Word without the flag-enable bit: flags must hold.
        in_valid = 1'b1; in_cntrl = 20'h00001;
        step();
        in_valid = 1'b0; in_cntrl = 20'h0; alu_flags = 4'b1111;
        #1;
        n_vec++;
        if (flags_fwd !== 4'b0110) begin
            n_err++;
            $display("FAIL flag_noen_fwd: fwd=%b, need 0110", flags_fwd);
        end
        step();
        n_vec++;
        if (flags !== 4'b0110) begin
            n_err++;
            $display("FAIL flag_noen_hold: flags=%b, need 0110", flags);
        end
        step(); step();
        alu_flags = 4'b0000;
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_cntrl = 20'h12345;
        step();
        in_cntrl = 20'h0ABCD;
        step();
        // B (bit15 set) sits in stage 0, but stall must block its flag write.
        stall = 1'b1; in_valid = 1'b1; in_cntrl = 20'hFFFFF; alu_flags = 4'b1001;
        #1;
        n_vec++;
        if (flags_fwd !== 4'b0110) begin
            n_err++;
            $display("FAIL stall_fwd: fwd=%b, need 0110", flags_fwd);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if (stage_valid !== 3'b011 || stage_cntrl !== {20'h0, 20'h12345, 20'h0ABCD}
                || occupancy !== 2'd2 || flags !== 4'b0110) begin
                n_err++;
                $display("FAIL stall_hold%0d: valid=%b cntrl=%h occ=%0d flags=%b, need 011 %h 2 0110",
                         c, stage_valid, stage_cntrl, occupancy, flags,
                         {20'h0, 20'h12345, 20'h0ABCD});
            end
        end
        stall = 1'b0; in_valid = 1'b0; in_cntrl = 20'h0;
        step();
        n_vec++;
        if (stage_valid !== 3'b110 || stage_cntrl !== {20'h12345, 20'h0ABCD, 20'h0}
            || occupancy !== 2'd2 || flags !== 4'b1001) begin
            n_err++;
            $display("FAIL stall_resume: valid=%b cntrl=%h occ=%0d flags=%b, need 110 %h 2 1001",
                     stage_valid, stage_cntrl, occupancy, flags, {20'h12345, 20'h0ABCD, 20'h0});
        end
        step(); step();
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_cntrl = 20'h00011; step();
        in_cntrl = 20'h00022; step();
        in_cntrl = 20'h00033; step();
        n_vec++;
        if (occupancy !== 2'd3 || stage_cntrl !== {20'h00011, 20'h00022, 20'h00033}) begin
            n_err++;
            $display("FAIL flush_fill: occ=%0d cntrl=%h, need 3 %h",
                     occupancy, stage_cntrl, {20'h00011, 20'h00022, 20'h00033});
        end
        stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_cntrl = 20'h0FFFF; alu_flags = 4'b1111;
        step();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cntrl = 20'h0; alu_flags = 4'b0000;
        n_vec++;
        if (occupancy !== 2'd0 || stage_valid !== 3'b000 || stage_cntrl !== 60'h0
            || flags !== 4'b1001) begin
            n_err++;
            $display("FAIL flush_stall: occ=%0d valid=%b cntrl=%h flags=%b, need 0 000 0 1001",
                     occupancy, stage_valid, stage_cntrl, flags);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_cntrl = 20'h00444; step();
        in_cntrl = 20'h00555; step();
        in_cntrl = 20'h00666; step();
        // Reset lands between edges: outputs must clear without a clock.
        reset = 1'b0;
        #1;
        n_vec++;
        if (stage_valid !== 3'b000 || stage_cntrl !== 60'h0 || occupancy !== 2'd0
            || flags !== 4'b0000 || flags_fwd !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b cntrl=%h occ=%0d flags=%b fwd=%b, need all zero",
                     stage_valid, stage_cntrl, occupancy, flags, flags_fwd);
        end
        in_valid = 1'b0; in_cntrl = 20'h0;
        #1;
        reset = 1'b1;
        step();
        n_vec++;
        if (stage_valid !== 3'b000 || stage_cntrl !== 60'h0 || flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_residue: valid=%b cntrl=%h flags=%b, need zero",
                     stage_valid, stage_cntrl, flags);
        end
        in_valid = 1'b1; in_cntrl = 20'h00777;
        step();
        in_valid = 1'b0; in_cntrl = 20'h0;
        n_vec++;
        if (stage_valid !== 3'b001 || stage_cntrl !== {20'h0, 20'h0, 20'h00777}) begin
            n_err++;
            $display("FAIL reset_resume: valid=%b cntrl=%h, need 001 %h",
                     stage_valid, stage_cntrl, {20'h0, 20'h0, 20'h00777});
        end
        step(); step();
    endtask

    task automatic test_back_to_back();
        logic [19:0] w [5];
        logic [59:0] exp_c;
        logic [2:0]  exp_v;
        logic [1:0]  exp_o;
        w[0] = 20'h00101; w[1] = 20'h00202; w[2] = 20'h00303;
        w[3] = 20'h00404; w[4] = 20'h00505;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cntrl = w[i];
            step();
            exp_c = {(i >= 2) ? w[(i >= 2) ? i - 2 : 0] : 20'h0,
                     (i >= 1) ? w[(i >= 1) ? i - 1 : 0] : 20'h0,
                     w[i]};
            exp_v = (i >= 2) ? 3'b111 : ((i == 1) ? 3'b011 : 3'b001);
            exp_o = (i >= 2) ? 2'd3 : ((i == 1) ? 2'd2 : 2'd1);
            n_vec++;
            if (stage_cntrl !== exp_c || stage_valid !== exp_v || occupancy !== exp_o) begin
                n_err++;
                $display("FAIL back_to_back%0d: cntrl=%h valid=%b occ=%0d, need %h %b %0d",
                         i, stage_cntrl, stage_valid, occupancy, exp_c, exp_v, exp_o);
            end
        end
        in_valid = 1'b0; in_cntrl = 20'h0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_latency();
        test_flags();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ctrl_pipe

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 20, control-word width in bits.
REQ-002 SHALL have parameter DEPTH, default 3, number of pipeline stages (legal 1..8).
REQ-003 SHALL have parameter FLAG_EN_BIT, default 15, index in the control word of the flag-write enable (legal 0..WIDTH-1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port in_valid  input  1  a new control word is presented.
REQ-007 SHALL have port in_cntrl  input  WIDTH  decoded control word entering stage 0.
REQ-008 SHALL have port stall  input  1  freeze all stages.
REQ-009 SHALL have port flush  input  1  kill all in-flight stages.
REQ-010 SHALL have port alu_flags  input  4  NZCV from the execute stage ([3]=N, [2]=Z, [1]=C, [0]=V).
REQ-011 SHALL have port stage_cntrl  output  DEPTH*WIDTH  registered control word per stage (stage k at bits [k*WIDTH +: WIDTH]).
REQ-012 SHALL have port stage_valid  output  DEPTH  registered valid bit per stage.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of set stage_valid bits.
REQ-014 SHALL have port flags  output  4  registered NZCV flag register.
REQ-015 SHALL have port flags_fwd  output  4  flags as seen by a consumer in the same cycle.

Function
REQ-016 SHALL advance every stage by one on each rising edge when stall=0 and flush=0: stage 0 takes in_valid/in_cntrl, stage k takes stage k-1.
REQ-017 SHALL store an all-zero control word in any stage whose incoming valid is 0 (bubbles are zero).
REQ-018 SHALL hold all stages, valids and flags unchanged while stall=1 and flush=0; in_cntrl is dropped.
REQ-019 SHALL clear all valids and control words to zero on the edge where flush=1, regardless of stall; in_valid is ignored that cycle.
REQ-020 SHALL define flag_wr = stage_valid[0] & stage_cntrl[0][FLAG_EN_BIT] & ~stall & ~flush.
REQ-021 SHALL load alu_flags into flags on an edge with flag_wr=1; otherwise flags hold.
REQ-022 SHALL drive occupancy combinationally from stage_valid, range 0..DEPTH.
REQ-023 SHALL give a control word a latency of exactly k+1 unstalled edges from in_valid to stage k.
REQ-024 SHALL make stage DEPTH-1 drop out of the pipe with no backpressure; the pipe never fills or blocks.

Reset
REQ-025 SHALL, while reset=0, immediately force stage_valid=0, stage_cntrl=0, flags=4'b0000, occupancy=0, independent of clk.
REQ-026 SHALL resume normal operation on the first rising edge after reset returns to 1, with no residual state from before reset.

Configuration
REQ-027 SHALL use the macro CTRL_PIPE_FWD_EN: when defined, flags_fwd = alu_flags while flag_wr=1, else flags; when undefined, flags_fwd = flags at all times, and the bypass mux is absent.

Structure
REQ-028 SHALL take NFLAGS=4, the flags_t 4-bit typedef and the NZCV bit-index constants from package ctrl_pipe_pkg.
REQ-029 SHALL instantiate DEPTH copies of a sub-module ctrl_stage (WIDTH-bit register plus valid, with enable and synchronous clear, asynchronous active-low reset).

Verification
REQ-030 SHALL cover: reset=0 mid-stream with 3 valids in flight -> all outputs 0 before next clk edge, occupancy=0.
REQ-031 SHALL cover: DEPTH=3, in_cntrl=20'h0_8001 valid for one cycle -> appears in stages 0, 1, 2 on edges 1, 2, 3, occupancy 1,1,1 then 0.
REQ-032 SHALL cover: stall=1 for 2 cycles with occupancy=2 -> stage contents and flags unchanged, then resume advancing.
REQ-033 SHALL cover: flush=1 and stall=1 together with occupancy=3 -> occupancy=0 and all stage_cntrl=0 after one edge.
REQ-034 SHALL cover: stage 0 valid with bit 15 set, alu_flags=4'b0110 -> flags=4'b0110 after edge; with CTRL_PIPE_FWD_EN, flags_fwd=4'b0110 in the same cycle; without it, flags_fwd equals old flags until the edge.
REQ-035 SHALL cover: stage 0 valid with bit 15 clear, alu_flags=4'b1111 -> flags unchanged.
